rob_tag_alloc: RTL

//  Free-list allocator for ROB tags: the source of Dispatch_Rd_tag/new_rd_tag on the dispatch side
//  and the sink of Retire_rd_tag/Retire_valid on the retire side. Tags are handed out in FIFO

---
 rtl/rob_tag_alloc_pkg.sv | 27 ++
 rtl/rob_tag_alloc_if.sv | 50 +++++
 rtl/rob_tag_alloc_tag_fifo_mem.sv | 27 ++
 rtl/rob_tag_alloc.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rob_tag_alloc_pkg.sv
// Shared ROB tag types, sizes and allocator FSM encoding.
// No logic, no latency.
// No flow control; types only.
package rob_tag_alloc_pkg;

    // Tag width matches the ROB Rd_tag width; one tag per ROB entry.
    localparam int ROB_TAG_W = 5;
    localparam int ROB_DEPTH = 1 << ROB_TAG_W;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [ROB_TAG_W:0]   rob_cnt_t;

    // Free_count value meaning "every tag is free".
    localparam rob_cnt_t ROB_FULL_CNT = rob_cnt_t'(ROB_DEPTH);

    // The allocator only ever leaves INIT once per reset.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } alloc_state_e;

    // Pointer advance; wraps silently because DEPTH is a power of two.
    function automatic rob_tag_t tag_inc(input rob_tag_t t);
        return t + 1'b1;
    endfunction

endpackage

// File: rtl/rob_tag_alloc_if.sv
// Dispatch/retire/flush bundle between the pipeline and the ROB tag allocator.
// No logic, no latency.
// Alloc_req is qualified by Alloc_tag_valid; a retire into a full list is flagged, not held.
interface rob_tag_alloc_if;
    import rob_tag_alloc_pkg::*;

    // Dispatch side
    logic     Alloc_req;
    rob_tag_t Alloc_tag;
    logic     Alloc_tag_valid;

    // Retire side
    rob_tag_t Retire_rd_tag;
    logic     Retire_valid;

    // Branch mispredict recovery
    logic     Flush;

    // Status
    rob_cnt_t Free_count;
    logic     Init_done;
    logic     Ret_error;

    // Pipeline side: requests tags, returns them, flushes.
    modport master (
        output Alloc_req,
        output Retire_rd_tag,
        output Retire_valid,
        output Flush,
        input  Alloc_tag,
        input  Alloc_tag_valid,
        input  Free_count,
        input  Init_done,
        input  Ret_error
    );

    // Allocator side.
    modport slave (
        input  Alloc_req,
        input  Retire_rd_tag,
        input  Retire_valid,
        input  Flush,
        output Alloc_tag,
        output Alloc_tag_valid,
        output Free_count,
        output Init_done,
        output Ret_error
    );

endinterface

// File: rtl/rob_tag_alloc_tag_fifo_mem.sv
// DEPTH x TAG_W tag storage for the free list: one synchronous write port, one async read port.
// Write lands on the rising edge; read data follows rd_addr combinationally (0 cycles).
// No backpressure; the owner guarantees writes only target free slots.
module tag_fifo_mem #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [TAG_W-1:0]         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [TAG_W-1:0]         rd_dat
);

    logic [TAG_W-1:0] mem_q [DEPTH];

    // Storage is not reset; the allocator's INIT phase fills every entry.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/rob_tag_alloc.sv
// FIFO free-list allocator for ROB tags: hands out tags at dispatch, takes them back at retire.
// Head tag is combinational from the read pointer; a taken tag is replaced by the next one after 1 cycle.
// Alloc_tag_valid drops when the list is empty; a retire into a full list is dropped and sets Ret_error.
module rob_tag_alloc
    import rob_tag_alloc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    rob_tag_alloc_if.slave   alloc_if
);

    alloc_state_e state_q, state_d;
    rob_tag_t     rd_ptr_q, rd_ptr_d;
    rob_tag_t     wr_ptr_q, wr_ptr_d;
    rob_tag_t     init_cnt_q, init_cnt_d;
    rob_cnt_t     free_cnt_q, free_cnt_d;
    logic         ret_error_q, ret_error_d;

    logic         mem_wr_en;
    rob_tag_t     mem_wr_addr;
    rob_tag_t     mem_wr_dat;
    rob_tag_t     head_tag;

    logic         run;
    logic         tag_vld;
    logic         list_full;
    logic         pop;
    logic         push;

    assign run       = (state_q == ST_RUN);
    assign tag_vld   = run && (free_cnt_q != '0);
    assign list_full = (free_cnt_q == ROB_FULL_CNT);

    // Flush overrides both handshakes for the cycle it is asserted.
    assign pop  = run && !alloc_if.Flush && alloc_if.Alloc_req && tag_vld;
    assign push = run && !alloc_if.Flush && alloc_if.Retire_valid && !list_full;

    tag_fifo_mem #(
        .TAG_W (ROB_TAG_W),
        .DEPTH (ROB_DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_dat  (mem_wr_dat),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head_tag)
    );

    // Next-state logic: INIT fills the list with tags 0..DEPTH-1, RUN services alloc/retire/flush.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        init_cnt_d  = init_cnt_q;
        free_cnt_d  = free_cnt_q;
        ret_error_d = ret_error_q;
        mem_wr_en   = 1'b0;
        mem_wr_addr = wr_ptr_q;
        mem_wr_dat  = alloc_if.Retire_rd_tag;

        case (state_q)
            ST_INIT: begin
                // One entry per cycle; the list is full when init_cnt wraps back to 0,
                // which also leaves rd_ptr == wr_ptr == 0.
                mem_wr_en   = 1'b1;
                mem_wr_addr = init_cnt_q;
                mem_wr_dat  = init_cnt_q;
                init_cnt_d  = tag_inc(init_cnt_q);
                free_cnt_d  = free_cnt_q + 1'b1;
                if (init_cnt_q == rob_tag_t'(ROB_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (alloc_if.Flush) begin
                    // Allocation and retirement are both in program order, so the
                    // in-flight tags still sit in mem[wr_ptr .. rd_ptr-1]. Moving
                    // wr_ptr up to rd_ptr re-frees them without rewriting storage.
                    wr_ptr_d   = rd_ptr_q;
                    free_cnt_d = ROB_FULL_CNT;
                end else begin
                    if (pop) begin
                        rd_ptr_d = tag_inc(rd_ptr_q);
                    end
                    if (push) begin
                        mem_wr_en = 1'b1;
                        wr_ptr_d  = tag_inc(wr_ptr_q);
                    end
                    if (pop && !push) begin
                        free_cnt_d = free_cnt_q - 1'b1;
                    end else if (push && !pop) begin
                        free_cnt_d = free_cnt_q + 1'b1;
                    end
                    // More tags returned than exist: upstream bug, keep it visible.
                    if (alloc_if.Retire_valid && list_full) begin
                        ret_error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State register: synchronous reset restarts the INIT fill from scratch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            init_cnt_q  <= '0;
            free_cnt_q  <= '0;
            ret_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            init_cnt_q  <= init_cnt_d;
            free_cnt_q  <= free_cnt_d;
            ret_error_q <= ret_error_d;
        end
    end

    assign alloc_if.Alloc_tag       = head_tag;
    assign alloc_if.Alloc_tag_valid = tag_vld;
    assign alloc_if.Free_count      = free_cnt_q;
    assign alloc_if.Init_done       = run;
    assign alloc_if.Ret_error       = ret_error_q;

endmodule
